// File: rtl/nla_pkg.sv
// Shared sizing for the NLA coefficient path (FSM, coefficient buffer, datapath).
package nla_pkg;
    localparam int NLA_DATA_W     = 16;
    localparam int NLA_ADDR_LINES = 4;

    // Usable entries: one less than the address space, so the count fits in ADDR_LINES bits.
    function automatic int nla_cap(input int addr_lines);
        return (1 << addr_lines) - 1;
    endfunction
endpackage

// File: rtl/coeff_buffer_ram.sv
// Coefficient storage: one write port, one synchronous read port with read enable, no reset.
module coeff_buffer_ram
    import nla_pkg::*;
#(
    parameter int ADDR_LINES = NLA_ADDR_LINES,
    parameter int DATA_W     = NLA_DATA_W
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_LINES-1:0] waddr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_LINES-1:0] raddr_i,
    output logic [DATA_W-1:0]     rdata_o
);
    logic [DATA_W-1:0] mem_q [2**ADDR_LINES];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/coeff_buffer.sv
// Coefficient buffer: loads a set once, then replays it in index order per evaluation.
module coeff_buffer
    import nla_pkg::*;
#(
    parameter int ADDR_LINES = NLA_ADDR_LINES,
    parameter int DATA_W     = NLA_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  wr_last,
    input  logic                  rd_en,
    input  logic                  redo,
    input  logic                  clear,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    output logic [ADDR_LINES-1:0] wr_ptr,
    output logic                  coeff_ready,
    output logic                  full,
    output logic                  rd_empty,
    output logic                  overflow_err,
    output logic                  underflow_err
);
    localparam logic [ADDR_LINES-1:0] CAP = ADDR_LINES'(nla_cap(ADDR_LINES));

    logic [ADDR_LINES-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_addr;
    logic                  ready_q, ready_d, vld_q, vld_d;
    logic                  ovf_q, ovf_d, udf_q, udf_d;
    logic                  zero_q, zero_d;
    logic                  full_w, wr_acc, rd_acc;
    logic [DATA_W-1:0]     ram_rdata;

    assign full_w  = (wr_ptr_q == CAP);
    // Rewind-and-read: redo makes this cycle's read target entry 0.
    assign rd_addr = redo ? '0 : rd_ptr_q;
    assign wr_acc  = !clear && wr_en && !ready_q && !full_w;
    assign rd_acc  = !clear && rd_en && ready_q && (rd_addr != wr_ptr_q);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ready_d  = ready_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        vld_d    = 1'b0;
        zero_d   = zero_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ready_d  = 1'b0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (wr_last || (wr_ptr_q == CAP - 1'b1)) ready_d = 1'b1;
            end else if (wr_en) begin
                ovf_d = 1'b1;
                if (wr_last && full_w) ready_d = 1'b1;
            end
            if (rd_acc) begin
                rd_ptr_d = rd_addr + 1'b1;
                vld_d    = 1'b1;
                zero_d   = 1'b0;
            end else begin
                if (redo) rd_ptr_d = '0;
                if (rd_en) udf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ready_q  <= 1'b0;
            vld_q    <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ready_q  <= ready_d;
            vld_q    <= vld_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            zero_q   <= zero_d;
        end
    end

    coeff_buffer_ram #(.ADDR_LINES(ADDR_LINES), .DATA_W(DATA_W)) u_ram (
        .clk     (clk),
        .we_i    (wr_acc && !rst),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data),
        .re_i    (rd_acc && !rst),
        .raddr_i (rd_addr),
        .rdata_o (ram_rdata)
    );

    // RAM has no reset; mask its output until the first read after reset.
    assign rd_data       = zero_q ? '0 : ram_rdata;
    assign rd_valid      = vld_q;
    assign wr_ptr        = wr_ptr_q;
    assign coeff_ready   = ready_q;
    assign full          = full_w;
    assign rd_empty      = (rd_ptr_q == wr_ptr_q);
    assign overflow_err  = ovf_q;
    assign underflow_err = udf_q;
endmodule

// File: tb/tb_coeff_buffer.sv
// Directed bench for coeff_buffer: load, replay, exhaustion, overflow, clear and reset.
module tb_coeff_buffer;
    logic        clk = 1'b0;
    logic        rst, wr_en, wr_last, rd_en, redo, clear;
    logic [15:0] wr_data;
    logic [15:0] rd_data;
    logic        rd_valid, coeff_ready, full, rd_empty, overflow_err, underflow_err;
    logic [3:0]  wr_ptr;
    int          vecs = 0;
    int          errs = 0;

    always #5 clk = ~clk;

    coeff_buffer #(.ADDR_LINES(4), .DATA_W(16)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_last(wr_last),
        .rd_en(rd_en), .redo(redo), .clear(clear), .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_ptr(wr_ptr), .coeff_ready(coeff_ready), .full(full), .rd_empty(rd_empty),
        .overflow_err(overflow_err), .underflow_err(underflow_err)
    );

    task automatic idle();
        rst = 0; wr_en = 0; wr_last = 0; rd_en = 0; redo = 0; clear = 0; wr_data = '0;
    endtask

    // Apply current inputs for one edge, land 1ns after it, return inputs to idle.
    task automatic step();
        @(posedge clk); #1;
        idle();
    endtask

    task automatic wr(input logic [15:0] d, input logic last);
        wr_en = 1; wr_data = d; wr_last = last; step();
    endtask

    task automatic test_reset();
        idle(); rst = 1; step(); rst = 1; step();
        vecs++; if (wr_ptr !== 4'd0 || coeff_ready !== 1'b0 || full !== 1'b0 || rd_empty !== 1'b1) begin
            errs++; $display("FAIL reset_ptrs got wp=%0d rdy=%b full=%b emp=%b exp 0 0 0 1", wr_ptr, coeff_ready, full, rd_empty); end
        vecs++; if (rd_data !== 16'h0 || rd_valid !== 1'b0 || overflow_err !== 1'b0 || underflow_err !== 1'b0) begin
            errs++; $display("FAIL reset_data got rd=%h v=%b ovf=%b udf=%b exp 0 0 0 0", rd_data, rd_valid, overflow_err, underflow_err); end
    endtask

    task automatic test_load3();
        wr(16'h0011, 0); wr(16'h0022, 0);
        vecs++; if (wr_ptr !== 4'd2 || coeff_ready !== 1'b0) begin
            errs++; $display("FAIL load3_mid got wp=%0d rdy=%b exp 2 0", wr_ptr, coeff_ready); end
        wr(16'h0033, 1);
        vecs++; if (wr_ptr !== 4'd3 || coeff_ready !== 1'b1 || rd_empty !== 1'b0) begin
            errs++; $display("FAIL load3_done got wp=%0d rdy=%b emp=%b exp 3 1 0", wr_ptr, coeff_ready, rd_empty); end
    endtask

    task automatic test_replay();
        logic [15:0] exp_d [3];
        exp_d[0] = 16'h0011; exp_d[1] = 16'h0022; exp_d[2] = 16'h0033;
        for (int i = 0; i < 3; i++) begin
            rd_en = 1; redo = (i == 0); step();
            vecs++; if (rd_valid !== 1'b1 || rd_data !== exp_d[i]) begin
                errs++; $display("FAIL replay_%0d got v=%b d=%h exp 1 %h", i, rd_valid, rd_data, exp_d[i]); end
        end
        vecs++; if (rd_empty !== 1'b1) begin
            errs++; $display("FAIL replay_empty got %b exp 1", rd_empty); end
    endtask

    task automatic test_underflow_redo();
        rd_en = 1; step();
        vecs++; if (rd_valid !== 1'b0 || rd_data !== 16'h0033 || underflow_err !== 1'b1) begin
            errs++; $display("FAIL underflow got v=%b d=%h udf=%b exp 0 0033 1", rd_valid, rd_data, underflow_err); end
        redo = 1; step();
        vecs++; if (rd_empty !== 1'b0 || rd_valid !== 1'b0) begin
            errs++; $display("FAIL redo_only got emp=%b v=%b exp 0 0", rd_empty, rd_valid); end
        rd_en = 1; step();
        vecs++; if (rd_valid !== 1'b1 || rd_data !== 16'h0011) begin
            errs++; $display("FAIL redo_replay got v=%b d=%h exp 1 0011", rd_valid, rd_data); end
        step();
        vecs++; if (rd_valid !== 1'b0 || rd_data !== 16'h0011) begin
            errs++; $display("FAIL valid_pulse got v=%b d=%h exp 0 0011", rd_valid, rd_data); end
    endtask

    task automatic test_clear();
        clear = 1; wr_en = 1; wr_data = 16'h0099; wr_last = 1; step();
        vecs++; if (wr_ptr !== 4'd0 || coeff_ready !== 1'b0 || underflow_err !== 1'b0 || rd_empty !== 1'b1) begin
            errs++; $display("FAIL clear_state got wp=%0d rdy=%b udf=%b emp=%b exp 0 0 0 1", wr_ptr, coeff_ready, underflow_err, rd_empty); end
        vecs++; if (rd_data !== 16'h0011) begin
            errs++; $display("FAIL clear_hold got %h exp 0011", rd_data); end
        rd_en = 1; step();
        vecs++; if (rd_valid !== 1'b0 || underflow_err !== 1'b1) begin
            errs++; $display("FAIL read_loading got v=%b udf=%b exp 0 1", rd_valid, underflow_err); end
        wr(16'h0055, 1);
        rd_en = 1; redo = 1; step();
        vecs++; if (wr_ptr !== 4'd1 || rd_valid !== 1'b1 || rd_data !== 16'h0055) begin
            errs++; $display("FAIL after_clear got wp=%0d v=%b d=%h exp 1 1 0055", wr_ptr, rd_valid, rd_data); end
    endtask

    task automatic test_full_overflow();
        clear = 1; step();
        for (int i = 0; i < 14; i++) wr(16'h0100 + 16'(i), 0);
        vecs++; if (full !== 1'b0 || coeff_ready !== 1'b0 || wr_ptr !== 4'd14) begin
            errs++; $display("FAIL pre_full got full=%b rdy=%b wp=%0d exp 0 0 14", full, coeff_ready, wr_ptr); end
        wr(16'h010E, 0);
        vecs++; if (full !== 1'b1 || coeff_ready !== 1'b1 || wr_ptr !== 4'd15 || overflow_err !== 1'b0) begin
            errs++; $display("FAIL full got full=%b rdy=%b wp=%0d ovf=%b exp 1 1 15 0", full, coeff_ready, wr_ptr, overflow_err); end
        wr(16'hDEAD, 0);
        vecs++; if (overflow_err !== 1'b1 || wr_ptr !== 4'd15) begin
            errs++; $display("FAIL overflow got ovf=%b wp=%0d exp 1 15", overflow_err, wr_ptr); end
        for (int i = 0; i < 15; i++) begin
            rd_en = 1; redo = (i == 0); step();
            vecs++; if (rd_valid !== 1'b1 || rd_data !== 16'h0100 + 16'(i)) begin
                errs++; $display("FAIL full_read_%0d got v=%b d=%h exp 1 %h", i, rd_valid, rd_data, 16'h0100 + 16'(i)); end
        end
        vecs++; if (rd_empty !== 1'b1) begin
            errs++; $display("FAIL full_empty got %b exp 1", rd_empty); end
    endtask

    task automatic test_rst_midload();
        clear = 1; step();
        wr(16'h0A01, 0); wr(16'h0A02, 0);
        rst = 1; wr_en = 1; wr_data = 16'h0A03; step();
        vecs++; if (wr_ptr !== 4'd0 || coeff_ready !== 1'b0 || full !== 1'b0 || rd_empty !== 1'b1) begin
            errs++; $display("FAIL rst_mid_ptrs got wp=%0d rdy=%b full=%b emp=%b exp 0 0 0 1", wr_ptr, coeff_ready, full, rd_empty); end
        vecs++; if (rd_data !== 16'h0 || rd_valid !== 1'b0 || overflow_err !== 1'b0 || underflow_err !== 1'b0) begin
            errs++; $display("FAIL rst_mid_data got rd=%h v=%b ovf=%b udf=%b exp 0 0 0 0", rd_data, rd_valid, overflow_err, underflow_err); end
        wr(16'h00AA, 1);
        rd_en = 1; redo = 1; step();
        vecs++; if (wr_ptr !== 4'd1 || rd_valid !== 1'b1 || rd_data !== 16'h00AA) begin
            errs++; $display("FAIL rst_reload got wp=%0d v=%b d=%h exp 1 1 00aa", wr_ptr, rd_valid, rd_data); end
    endtask

    initial begin
        idle();
        test_reset();
        test_load3();
        test_replay();
        test_underflow_redo();
        test_clear();
        test_full_overflow();
        test_rst_midload();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
